// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM state type and flag indices for ALU issue.   |
// | Optional macro ALU_ISSUE_MULT_EN enables MULT/MULTU.  Rev 1.0       |
// +--------------------------------------------------------------------+
package alu_pkg;

    localparam logic [5:0] c_op_add   = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b000001;
    localparam logic [5:0] c_op_mult  = 6'b000010;
    localparam logic [5:0] c_op_multu = 6'b000011;
    localparam logic [5:0] c_op_comp  = 6'b000100;
    localparam logic [5:0] c_op_compi = 6'b000101;
    localparam logic [5:0] c_op_and   = 6'b000110;
    localparam logic [5:0] c_op_xor   = 6'b000111;
    localparam logic [5:0] c_op_shll  = 6'b001000;
    localparam logic [5:0] c_op_shrl  = 6'b001001;
    localparam logic [5:0] c_op_shllv = 6'b001010;
    localparam logic [5:0] c_op_shrlv = 6'b001011;
    localparam logic [5:0] c_op_shra  = 6'b001100;
    localparam logic [5:0] c_op_shrav = 6'b001101;
    localparam logic [5:0] c_op_nop   = 6'b111111;

    localparam int c_flg_carry = 3;
    localparam int c_flg_zero  = 2;
    localparam int c_flg_sign  = 1;
    localparam int c_flg_ovf   = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_mult(input logic [5:0] op);
        return (op == c_op_mult) || (op == c_op_multu);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
`ifdef ALU_ISSUE_MULT_EN
        return op <= c_op_shrav;
`else
        return (op <= c_op_shrav) && !is_mult(op);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_operand_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_operand_mux : selects the second ALU operand for a latched op.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_operand_mux
    import alu_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [31:0] i_rt,
    input  logic [15:0] i_imm,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_inp2
);

    always_comb begin
        o_inp2 = i_rt;
        case (i_op)
            c_op_addi, c_op_compi:          o_inp2 = {{16{i_imm[15]}}, i_imm};
            c_op_shll, c_op_shrl, c_op_shra: o_inp2 = {27'd0, i_shamt};
            default:                        o_inp2 = i_rt;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_issue_ctrl : single-request ALU issue/writeback controller.     |
// | Optional macro ALU_ISSUE_MULT_EN adds MULT/MULTU and hi/lo. Rev 1.0 |
// +--------------------------------------------------------------------+
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic [15:0] req_imm,
    input  logic [4:0]  req_shamt,
    input  logic [4:0]  req_rd,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    input  logic [31:0] alu_out,
    input  logic [63:0] alu_mulout,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_ovf,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [3:0]  flags,
    output logic        illegal
);

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_bad_req;
    logic [5:0]  r_op;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [15:0] r_imm;
    logic [4:0]  r_shamt;
    logic [4:0]  r_rd;
    logic [31:0] r_wb_data;
    logic [3:0]  r_flags;
    logic        r_illegal;

    assign w_accept  = (r_state == S_IDLE) && req_valid && is_legal(req_op);
    assign w_bad_req = (r_state == S_IDLE) && req_valid && !is_legal(req_op);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  if (wb_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_op      <= c_op_nop;
            r_rs      <= '0;
            r_rt      <= '0;
            r_imm     <= '0;
            r_shamt   <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_bad_req;
            if (w_accept) begin
                r_op    <= req_op;
                r_rs    <= req_rs;
                r_rt    <= req_rt;
                r_imm   <= req_imm;
                r_shamt <= req_shamt;
                r_rd    <= req_rd;
            end
            if (r_state == S_EXEC) begin
                r_wb_data <= is_mult(r_op) ? 32'd0 : alu_out;
                r_flags   <= {alu_carry, alu_zero, alu_sign, alu_ovf};
            end
        end
    end

`ifdef ALU_ISSUE_MULT_EN
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == S_EXEC) && is_mult(r_op)) begin
            r_hi <= alu_mulout[63:32];
            r_lo <= alu_mulout[31:0];
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;
`else
    // Product bus has no consumer when multiply support is compiled out.
    logic w_unused_mulout;
    assign w_unused_mulout = ^alu_mulout;
    assign hi = '0;
    assign lo = '0;
`endif

    alu_operand_mux u_operand_mux (
        .i_op    (r_op),
        .i_rt    (r_rt),
        .i_imm   (r_imm),
        .i_shamt (r_shamt),
        .o_inp2  (alu_inp2)
    );

    assign req_ready  = (r_state == S_IDLE);
    assign alu_opcode = (r_state == S_EXEC) ? r_op : c_op_nop;
    assign alu_inp1   = r_rs;
    assign wb_valid   = (r_state == S_DONE);
    assign wb_we      = (r_state == S_DONE) && !is_mult(r_op);
    assign wb_rd      = r_rd;
    assign wb_data    = r_wb_data;
    assign flags      = r_flags;
    assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_issue_ctrl : table + scoreboard bench with a behavioural ALU.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_alu_issue_ctrl;

    localparam logic [5:0] OP_ADD = 6'd0, OP_ADDI = 6'd1, OP_MULT = 6'd2, OP_COMP = 6'd4,
                           OP_COMPI = 6'd5, OP_AND = 6'd6, OP_XOR = 6'd7, OP_SHLL = 6'd8,
                           OP_SHRL = 6'd9, OP_SHLLV = 6'd10, OP_SHRLV = 6'd11, OP_SHRA = 6'd12,
                           OP_SHRAV = 6'd13, OP_NOP = 6'h3F, OP_BAD = 6'b111000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_rs = '0, req_rt = '0;
    logic [15:0] req_imm = '0;
    logic [4:0]  req_shamt = '0, req_rd = '0;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_inp1, alu_inp2, alu_out;
    logic [63:0] alu_mulout;
    logic        alu_carry, alu_zero, alu_sign, alu_ovf;
    logic        wb_valid, wb_we, illegal;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, hi, lo;
    logic [3:0]  flags;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
        .req_shamt(req_shamt), .req_rd(req_rd), .alu_opcode(alu_opcode),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_out(alu_out),
        .alu_mulout(alu_mulout), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_sign(alu_sign), .alu_ovf(alu_ovf), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .hi(hi), .lo(lo), .flags(flags), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Behavioural ALU answering whatever the controller presents.
    logic [32:0] s33;
    always_comb begin
        s33 = '0; alu_out = '0; alu_mulout = '0;
        alu_carry = 1'b0; alu_ovf = 1'b0;
        case (alu_opcode)
            OP_ADD, OP_ADDI: begin
                s33 = {1'b0, alu_inp1} + {1'b0, alu_inp2};
                alu_out = s33[31:0]; alu_carry = s33[32];
                alu_ovf = (alu_inp1[31] == alu_inp2[31]) && (alu_out[31] != alu_inp1[31]);
            end
            OP_COMP, OP_COMPI: begin
                s33 = {1'b0, alu_inp1} - {1'b0, alu_inp2};
                alu_out = s33[31:0]; alu_carry = s33[32];
                alu_ovf = (alu_inp1[31] != alu_inp2[31]) && (alu_out[31] != alu_inp1[31]);
            end
            OP_MULT:  alu_mulout = {{32{alu_inp1[31]}}, alu_inp1} * {{32{alu_inp2[31]}}, alu_inp2};
            6'd3:     alu_mulout = {32'd0, alu_inp1} * {32'd0, alu_inp2};
            OP_AND:   alu_out = alu_inp1 & alu_inp2;
            OP_XOR:   alu_out = alu_inp1 ^ alu_inp2;
            OP_SHLL, OP_SHLLV: alu_out = alu_inp1 << alu_inp2[4:0];
            OP_SHRL, OP_SHRLV: alu_out = alu_inp1 >> alu_inp2[4:0];
            OP_SHRA, OP_SHRAV: alu_out = 32'($signed(alu_inp1) >>> alu_inp2[4:0]);
            default: alu_out = '0;
        endcase
        if (alu_opcode == OP_MULT || alu_opcode == 6'd3) begin
            alu_out  = alu_mulout[31:0];
            alu_zero = (alu_mulout == 64'd0);
            alu_sign = alu_mulout[63];
        end else begin
            alu_zero = (alu_out == 32'd0);
            alu_sign = alu_out[31];
        end
    end

    typedef struct {
        logic [5:0] op; logic [31:0] rs; logic [31:0] rt; logic [15:0] imm;
        logic [4:0] shamt; logic [4:0] rd; logic [31:0] inp2; logic [31:0] data;
        logic [3:0] flags; logic we;
    } vec_t;

    typedef struct {
        logic [31:0] data; logic we; logic [4:0] rd; logic [3:0] flags;
        logic [31:0] hi; logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [3:0]  last_flags = '0;
    logic [31:0] cur_hi = '0, cur_lo = '0;
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [15:0] imm, input logic [4:0] shamt, input logic [4:0] rd,
                                input logic [31:0] inp2, input logic [31:0] data,
                                input logic [3:0] fl, input logic we);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.imm = imm; v.shamt = shamt; v.rd = rd;
        v.inp2 = inp2; v.data = data; v.flags = fl; v.we = we;
        return v;
    endfunction

    // Scoreboard: pop and compare on every writeback handshake.
    always @(negedge clk) begin
        if (rst && wb_valid && wb_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_wb", 64'(wb_valid), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wb_data", 64'(wb_data), 64'(e.data));
                chk("wb_we", 64'(wb_we), 64'(e.we));
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("flags", 64'(flags), 64'(e.flags));
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
            end
        end
    end

    task automatic run_op(input vec_t v, input int stall);
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_op = v.op; req_rs = v.rs; req_rt = v.rt; req_imm = v.imm;
        req_shamt = v.shamt; req_rd = v.rd; req_valid = 1'b1;
        wb_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 6'($urandom); req_rs = $urandom; req_rt = $urandom;
        req_imm = 16'($urandom); req_shamt = 5'($urandom); req_rd = 5'($urandom);
        e.data = v.data; e.we = v.we; e.rd = v.rd; e.flags = v.flags; e.hi = cur_hi; e.lo = cur_lo;
        sbq.push_back(e);
        chk("exec_opcode", 64'(alu_opcode), 64'(v.op));
        chk("exec_inp1", 64'(alu_inp1), 64'(v.rs));
        chk("exec_inp2", 64'(alu_inp2), 64'(v.inp2));
        chk("exec_wb_valid", 64'(wb_valid), 64'd0);
        chk("exec_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        chk("done_wb_valid", 64'(wb_valid), 64'd1);
        chk("done_opcode_nop", 64'(alu_opcode), 64'(OP_NOP));
        for (int i = 0; i < stall; i++) begin
            chk("stall_wb_valid", 64'(wb_valid), 64'd1);
            chk("stall_wb_data", 64'(wb_data), 64'(v.data));
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        chk("back_idle_req_ready", 64'(req_ready), 64'd1);
        chk("back_idle_wb_valid", 64'(wb_valid), 64'd0);
        last_flags = v.flags;
    endtask

    task automatic illegal_req(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        req_op = op; req_rs = rs; req_rt = rt; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("illegal_pulse", 64'(illegal), 64'd1);
        chk("illegal_req_ready", 64'(req_ready), 64'd1);
        chk("illegal_flags_kept", 64'(flags), 64'(last_flags));
        chk("illegal_hi_kept", 64'(hi), 64'(cur_hi));
        chk("illegal_lo_kept", 64'(lo), 64'(cur_lo));
        @(posedge clk); #1;
        chk("illegal_one_cycle", 64'(illegal), 64'd0);
        chk("illegal_stays_idle", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0]  = mk(OP_ADD,   32'h7FFFFFFF, 32'h1,        16'h0,    5'd0,  5'd1,  32'h1,        32'h80000000, 4'b0011, 1'b1);
        tbl[1]  = mk(OP_ADDI,  32'h5,        32'hDEAD,     16'hFFFF, 5'd0,  5'd2,  32'hFFFFFFFF, 32'h4,        4'b1000, 1'b1);
        tbl[2]  = mk(OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 16'h0,    5'd0,  5'd3,  32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1'b1);
        tbl[3]  = mk(OP_XOR,   32'hAAAAAAAA, 32'hAAAAAAAA, 16'h0,    5'd0,  5'd4,  32'hAAAAAAAA, 32'h0,        4'b0100, 1'b1);
        tbl[4]  = mk(OP_SHLL,  32'h1,        32'h5,        16'h0,    5'd31, 5'd5,  32'h1F,       32'h80000000, 4'b0010, 1'b1);
        tbl[5]  = mk(OP_SHRL,  32'h80000000, 32'h0,        16'h0,    5'd4,  5'd6,  32'h4,        32'h08000000, 4'b0000, 1'b1);
        tbl[6]  = mk(OP_SHLLV, 32'h3,        32'h24,       16'h0,    5'd0,  5'd7,  32'h24,       32'h30,       4'b0000, 1'b1);
        tbl[7]  = mk(OP_SHRAV, 32'h80000000, 32'h8,        16'h0,    5'd0,  5'd8,  32'h8,        32'hFF800000, 4'b0010, 1'b1);
        tbl[8]  = mk(OP_SHRLV, 32'hFFFFFFFF, 32'h1C,       16'h0,    5'd0,  5'd9,  32'h1C,       32'hF,        4'b0000, 1'b1);
        tbl[9]  = mk(OP_COMPI, 32'h3,        32'h77,       16'hFFFF, 5'd0,  5'd10, 32'hFFFFFFFF, 32'h4,        4'b1000, 1'b1);
        tbl[10] = mk(OP_COMP,  32'h5,        32'h5,        16'h0,    5'd0,  5'd11, 32'h5,        32'h0,        4'b0100, 1'b1);
        tbl[11] = mk(OP_ADD,   32'hFFFFFFFF, 32'h1,        16'h0,    5'd0,  5'd12, 32'h1,        32'h0,        4'b1100, 1'b1);
        tbl[12] = mk(OP_ADDI,  32'h1,        32'h9,        16'h0005, 5'd3,  5'd14, 32'h5,        32'h6,        4'b0000, 1'b1);
        tbl[13] = mk(OP_SHRA,  32'h80000000, 32'h0,        16'h0,    5'd4,  5'd13, 32'h4,        32'hF8000000, 4'b0010, 1'b1);

        // Reset values
        #12;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_opcode_nop", 64'(alu_opcode), 64'(OP_NOP));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) run_op(tbl[i], 0);

        // Multiply: legal with hi/lo when enabled, illegal otherwise
`ifdef ALU_ISSUE_MULT_EN
        cur_hi = 32'hFFFFFFFF; cur_lo = 32'hFFFFFFFA;
        v = mk(OP_MULT, 32'hFFFFFFFE, 32'h3, 16'h0, 5'd0, 5'd15, 32'h3, 32'h0, 4'b0010, 1'b0);
        run_op(v, 0);
`else
        illegal_req(OP_MULT, 32'hFFFFFFFE, 32'h3);
        chk("nomult_hi", 64'(hi), 64'd0);
        chk("nomult_lo", 64'(lo), 64'd0);
`endif

        // Arithmetic shift with a 3-cycle writeback stall
        run_op(tbl[13], 3);

        illegal_req(OP_BAD, 32'h12345678, 32'h9ABCDEF0);

        // Reset in the middle of EXEC discards the operation
        @(negedge clk);
        req_op = OP_AND; req_rs = 32'hFFFFFFFF; req_rt = 32'h0FF0; req_rd = 5'd20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_in_exec", 64'(alu_opcode), 64'(OP_AND));
        rst = 1'b0;
        #1;
        chk("rstmid_wb_valid", 64'(wb_valid), 64'd0);
        chk("rstmid_wb_we", 64'(wb_we), 64'd0);
        chk("rstmid_flags", 64'(flags), 64'd0);
        chk("rstmid_hilo", {hi, lo}, 64'd0);
        chk("rstmid_wb_data", 64'(wb_data), 64'd0);
        chk("rstmid_wb_rd", 64'(wb_rd), 64'd0);
        chk("rstmid_opcode", 64'(alu_opcode), 64'(OP_NOP));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_no_wb_after", 64'(wb_valid), 64'd0);
        last_flags = '0; cur_hi = '0; cur_lo = '0;
        v = mk(OP_AND, 32'hF0F0F0F0, 32'hFFFF0000, 16'h0, 5'd0, 5'd21, 32'hFFFF0000, 32'hF0F00000, 4'b0010, 1'b1);
        run_op(v, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
